// File: rtl/uart_peek_controller.sv
// UART debug peek sequencer: collects a 5-byte command (address LSB-first,
// then core ID), issues one 32-bit read to the fabric, waits for data or a
// timeout, then streams back a 5-byte status/data frame.
module uart_peek_controller #(
  parameter int unsigned CORE_COUNT   = 4,
  parameter int unsigned BYTE_TIMEOUT = 100000,
  parameter int unsigned RESP_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [7:0]  req_id,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        busy
);

  localparam int unsigned TMR_W = 32;
  localparam logic [TMR_W-1:0] BYTE_LAST = TMR_W'(BYTE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RESP_LAST = TMR_W'(RESP_TIMEOUT - 1);
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_ID  = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [2:0] LAST_BYTE  = 3'd4;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [2:0]        cnt_q,       cnt_d;
  logic [31:0]       addr_q,      addr_d;
  logic [TMR_W-1:0]  idle_q,      idle_d;
  logic [TMR_W-1:0]  rtmr_q,      rtmr_d;
  logic [7:0]        status_q,    status_d;
  logic [31:0]       data_q,      data_d;
  logic [2:0]        idx_q,       idx_d;
  logic              tx_valid_q,  tx_valid_d;
  logic [7:0]        tx_data_q,   tx_data_d;
  logic              req_valid_q, req_valid_d;
  logic [7:0]        req_id_q,    req_id_d;
  logic [31:0]       req_addr_q,  req_addr_d;
  logic              busy_q;

  // Response frame byte: status first, then data LSB-first.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [7:0]  st,
                                            input logic [31:0] d);
    case (idx)
      3'd0:    frame_byte = st;
      3'd1:    frame_byte = d[7:0];
      3'd2:    frame_byte = d[15:8];
      3'd3:    frame_byte = d[23:16];
      3'd4:    frame_byte = d[31:24];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    idle_d      = idle_q;
    rtmr_d      = rtmr_q;
    status_d    = status_q;
    data_d      = data_q;
    idx_d       = idx_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    req_addr_d  = req_addr_q;

    case (state_q)
      S_COLLECT: begin
        if (rx_valid) begin
          idle_d = '0;
          if (cnt_q == LAST_BYTE) begin
            cnt_d = '0;
            idx_d = '0;
            if (TMR_W'(rx_data) < CORE_COUNT) begin
              req_id_d   = rx_data;
              req_addr_d = addr_q;
              state_d    = S_ISSUE;
            end else begin
              status_d = ST_BAD_ID;
              data_d   = '0;
              state_d  = S_SEND;
            end
          end else begin
            addr_d[{cnt_q[1:0], 3'b000} +: 8] = rx_data;
            cnt_d = cnt_q + 3'd1;
          end
        end else if (cnt_q != '0) begin
          // A stalled partial command is dropped so the host can resync.
          if (idle_q >= BYTE_LAST) begin
            cnt_d  = '0;
            idle_d = '0;
          end else begin
            idle_d = idle_q + TMR_W'(1);
          end
        end
      end

      S_ISSUE: begin
        req_valid_d = 1'b1;
        if (req_valid_q && req_ready) begin
          req_valid_d = 1'b0;
          rtmr_d      = '0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        // A response on the expiry cycle takes priority over the timeout.
        if (resp_valid) begin
          status_d = ST_OK;
          data_d   = resp_data;
          state_d  = S_SEND;
        end else if (rtmr_q >= RESP_LAST) begin
          status_d = ST_TIMEOUT;
          data_d   = '0;
          state_d  = S_SEND;
        end else begin
          rtmr_d = rtmr_q + TMR_W'(1);
        end
      end

      S_SEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(idx_q, status_q, data_q);
        end else if (tx_ready) begin
          if (idx_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            cnt_d      = '0;
            state_d    = S_COLLECT;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = frame_byte(idx_q + 3'd1, status_q, data_q);
          end
        end
      end

      default: state_d = S_COLLECT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_COLLECT;
      cnt_q       <= '0;
      addr_q      <= '0;
      idle_q      <= '0;
      rtmr_q      <= '0;
      status_q    <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      req_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      idle_q      <= idle_d;
      rtmr_q      <= rtmr_d;
      status_q    <= status_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
      req_addr_q  <= req_addr_d;
      busy_q      <= (state_d != S_COLLECT);
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign req_valid = req_valid_q;
  assign req_id    = req_id_q;
  assign req_addr  = req_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_peek_controller.sv
// Bench for uart_peek_controller: directed table, random peeks against a
// frame-level reference model, and hand-written reset/resync sequences.
module tb_uart_peek_controller;

  localparam int unsigned CORE_COUNT   = 4;
  localparam int unsigned BYTE_TIMEOUT = 50;
  localparam int unsigned RESP_TIMEOUT = 16;
  localparam int BUDGET = 400;
  localparam int NRAND  = 30;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_id;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [39:0] cmd;        // byte k of the command at [8k +: 8]
    int          gap_pos;    // idle gap inserted after this byte (-1: none)
    int          gap_len;
    int          resp_dly;   // cycles from request handshake to response (0: never)
    logic [31:0] rdata;
    int          req_stall;  // cycles req_ready is held low while req_valid
    bit          tx_alt;     // tx_ready toggles instead of staying high
    bit          inject;     // push stray rx bytes while busy
    logic [39:0] exp_frame;  // frame byte k at [8k +: 8]
    bit          exp_req;
  } vec_t;

  uart_peek_controller #(
    .CORE_COUNT  (CORE_COUNT),
    .BYTE_TIMEOUT(BYTE_TIMEOUT),
    .RESP_TIMEOUT(RESP_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: frame the host should see for a command and a response delay.
  function automatic logic [39:0] model_frame(input logic [39:0] cmd, input int dly,
                                              input logic [31:0] rd);
    if (int'(cmd[39:32]) >= int'(CORE_COUNT)) return {32'h0, 8'h01};
    if (dly >= 1 && dly <= int'(RESP_TIMEOUT)) return {rd, 8'h00};
    return {32'h0, 8'h02};
  endfunction

  function automatic vec_t mk(input logic [39:0] cmd, input int gp, input int gl,
                              input int dly, input logic [31:0] rd, input int st,
                              input bit alt, input bit inj, input logic [39:0] ef,
                              input bit er);
    vec_t v;
    v.cmd = cmd; v.gap_pos = gp; v.gap_len = gl; v.resp_dly = dly; v.rdata = rd;
    v.req_stall = st; v.tx_alt = alt; v.inject = inj; v.exp_frame = ef; v.exp_req = er;
    return v;
  endfunction

  task automatic send_cmd(input logic [39:0] cmd, input int gap_pos, input int gap_len);
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1;
      rx_data  = cmd[8*i +: 8];
      step();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      if (i == gap_pos) repeat (gap_len) step();
    end
  endtask

  // Plays fabric and transmitter for one peek; observation t follows edge t,
  // edge 0 being the one that took the fifth command byte.
  task automatic run_txn(input vec_t v, input string tag);
    logic [39:0] frame = '0;
    int nbytes = 0, req_first = -1, req_cnt = 0, req_wait = 0;
    int resp_at = -1, tx_first = -1, hold_err = 0;
    bit prev_stall = 0, done = 0, got_req = 0, last_hs;
    logic [7:0]  prev_data = '0;
    logic [7:0]  got_id = 'x;
    logic [31:0] got_addr = 'x;
    for (int t = 0; t < BUDGET && !done; t++) begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) hold_err++;
      if (req_valid) begin
        if (req_first < 0) req_first = t;
        req_cnt++;
      end
      if (tx_valid && tx_first < 0) tx_first = t;
      req_ready  = req_valid ? (req_wait >= v.req_stall) : 1'($urandom_range(0, 1));
      if (req_valid) req_wait++;
      tx_ready   = v.tx_alt ? 1'(t & 1) : 1'b1;
      resp_valid = (t == resp_at);
      resp_data  = resp_valid ? v.rdata : $urandom;
      last_hs    = 1'b0;
      if (req_valid && req_ready && !got_req) begin
        got_req  = 1'b1;
        got_id   = req_id;
        got_addr = req_addr;
        if (v.resp_dly > 0) resp_at = t + v.resp_dly;
      end
      if (tx_valid && tx_ready) begin
        if (nbytes < 5) frame[8*nbytes +: 8] = tx_data;
        nbytes++;
        last_hs = (nbytes == 5);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      rx_valid   = 1'b0;
      if (v.inject && busy && (last_hs || $urandom_range(0, 2) == 0)) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
      end
      step();
      if (last_hs) done = 1'b1;
    end
    rx_valid = 1'b0; resp_valid = 1'b0; req_ready = 1'b0; tx_ready = 1'b1;
    chk({tag, ".complete"}, 64'(done), 64'd1);
    chk({tag, ".frame"}, 64'(frame), 64'(v.exp_frame));
    chk({tag, ".busy_after"}, 64'(busy), 64'd0);
    chk({tag, ".txv_after"}, 64'(tx_valid), 64'd0);
    if (v.exp_req) begin
      chk({tag, ".req_id"}, 64'(got_id), 64'(v.cmd[39:32]));
      chk({tag, ".req_addr"}, 64'(got_addr), 64'(v.cmd[31:0]));
      chk({tag, ".req_lat"}, 64'(req_first), 64'd1);
    end else begin
      chk({tag, ".no_req"}, 64'(req_cnt), 64'd0);
    end
    if (v.exp_frame[7:0] == 8'h00)
      chk({tag, ".tx_lat"}, 64'(tx_first), 64'(resp_at + 2));
    if (v.tx_alt) chk({tag, ".tx_hold"}, 64'(hold_err), 64'd0);
  endtask

  // One peek followed by a stray response pulse while idle.
  task automatic run_vec(input vec_t v, input string tag);
    send_cmd(v.cmd, v.gap_pos, v.gap_len);
    run_txn(v, tag);
    resp_valid = 1'b1;
    resp_data  = $urandom;
    step();
    resp_valid = 1'b0;
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;

    tbl[0] = mk(40'h03_0000_023C, -1, 0,  3, 32'h1234_5678,  0, 0, 0, 40'h12_3456_7800, 1);
    tbl[1] = mk(40'h09_0000_0000, -1, 0,  3, 32'hFFFF_FFFF,  0, 0, 0, 40'h00_0000_0001, 0);
    tbl[2] = mk(40'h04_89AB_CDEF, -1, 0,  3, 32'hFFFF_FFFF,  0, 0, 0, 40'h00_0000_0001, 0);
    tbl[3] = mk(40'h01_DEAD_BEEF, -1, 0, 18, 32'h55AA_55AA,  0, 0, 0, 40'h00_0000_0002, 1);
    tbl[4] = mk(40'h02_0000_0010, -1, 0,  0, 32'h0,          0, 0, 0, 40'h00_0000_0002, 1);
    tbl[5] = mk(40'h02_0BAD_F00D, -1, 0, 16, 32'hA5A5_0F0F,  0, 0, 0, 40'hA5_A50F_0F00, 1);
    tbl[6] = mk(40'h00_0000_0004, -1, 0, 17, 32'h0000_0001,  0, 0, 0, 40'h00_0000_0002, 1);
    tbl[7] = mk(40'h00_1357_9BDF, -1, 0,  5, 32'hCAFE_F00D, 10, 1, 1, 40'hCA_FEF0_0D00, 1);
    tbl[8] = mk(40'h03_7654_3210,  1, 49, 1, 32'h0000_0080,  0, 0, 0, 40'h00_0000_8000, 1);
    tbl[9] = mk(40'h03_FFFF_FFFF, -1, 0,  2, 32'h8000_0001,  3, 1, 1, 40'h80_0000_0100, 1);

    // Reset values
    repeat (3) step();
    chk("rst.tx_valid", 64'(tx_valid), 64'd0);
    chk("rst.tx_data", 64'(tx_data), 64'd0);
    chk("rst.req_valid", 64'(req_valid), 64'd0);
    chk("rst.req_id", 64'(req_id), 64'd0);
    chk("rst.req_addr", 64'(req_addr), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Resync: a stalled 2-byte prefix must be discarded
    rx_valid = 1'b1; rx_data = 8'hAA; step();
    rx_data = 8'hBB; step();
    rx_valid = 1'b0;
    repeat (60) step();
    run_vec(mk(40'h01_0000_0240, -1, 0, 2, 32'h00C0_FFEE, 0, 0, 0, 40'h00_C0FF_EE00, 1),
            "resync");

    // Reset while waiting for the response
    send_cmd(40'h02_1122_3344, -1, 0);
    req_ready = 1'b1;
    repeat (5) step();
    chk("rstw.pre_busy", 64'(busy), 64'd1);
    chk("rstw.pre_id", 64'(req_id), 64'd2);
    #3 rst = 1'b1;
    #1;
    chk("rstw.tx_valid", 64'(tx_valid), 64'd0);
    chk("rstw.tx_data", 64'(tx_data), 64'd0);
    chk("rstw.req_valid", 64'(req_valid), 64'd0);
    chk("rstw.req_id", 64'(req_id), 64'd0);
    chk("rstw.req_addr", 64'(req_addr), 64'd0);
    chk("rstw.busy", 64'(busy), 64'd0);
    req_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_vec(mk(40'h01_0000_0ABC, -1, 0, 4, 32'h0BAD_CAFE, 0, 0, 0, 40'h0B_ADCA_FE00, 1),
            "post_rst");

    // Random peeks against the frame model
    for (int i = 0; i < NRAND; i++) begin
      rv.cmd       = {8'($urandom_range(0, 5)), 32'($urandom)};
      rv.gap_pos   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      rv.gap_len   = int'($urandom_range(0, BYTE_TIMEOUT - 1));
      rv.resp_dly  = int'($urandom_range(0, 20));
      rv.rdata     = $urandom;
      rv.req_stall = int'($urandom_range(0, 4));
      rv.tx_alt    = 1'($urandom_range(0, 1));
      rv.inject    = 1'($urandom_range(0, 1));
      rv.exp_frame = model_frame(rv.cmd, rv.resp_dly, rv.rdata);
      rv.exp_req   = (int'(rv.cmd[39:32]) < int'(CORE_COUNT));
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
